// File: rtl/stream_eot_sink.sv
// stream_eot_sink: drains a 33-bit EoT-terminated stream, counting payload
// words and summing them mod 2^DATA_W, with ap_ctrl_hs-style start/done.
// Optional build macro STREAM_EOT_SINK_THROTTLE_EN adds an LFSR that
// randomly withholds reads to emulate a slow consumer.
module stream_eot_sink #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W:0]   in_s_dout,
  input  logic              in_s_empty_n,
  output logic              in_s_read,
  input  logic [CNT_W-1:0]  n,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] checksum,
  output logic              mismatch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  n_latched;
  logic              start_run;
  logic              eot;
  logic              read_enable;

  assign start_run = (state == IDLE) && ap_start;
  assign eot       = in_s_dout[DATA_W];

`ifdef STREAM_EOT_SINK_THROTTLE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci feedback for taps 16,14,13,11
  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign read_enable = lfsr[0];

  // Throttle LFSR: reseeded on reset and start, steps on every RUN cycle
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      lfsr <= LFSR_SEED;
    end else if (start_run) begin
      lfsr <= LFSR_SEED;
    end else if (state == RUN) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign read_enable = 1'b1;
`endif

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; reset masks the stream read
  always_comb begin
    state_next = state;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    ap_ready   = 1'b0;
    in_s_read  = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        in_s_read = in_s_empty_n && read_enable;
        if (in_s_read && eot) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ap_done    = 1'b1;
        ap_ready   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (ap_rst) begin
      in_s_read = 1'b0;
    end
  end

  // Run statistics: cleared on start, updated on each consumed word,
  // mismatch resolved when the close token is consumed
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      count     <= '0;
      checksum  <= '0;
      mismatch  <= 1'b0;
      n_latched <= '0;
    end else if (start_run) begin
      count     <= '0;
      checksum  <= '0;
      mismatch  <= 1'b0;
      n_latched <= n;
    end else if (in_s_read) begin
      if (!eot) begin
        count    <= count + CNT_W'(1);
        checksum <= checksum + in_s_dout[DATA_W-1:0];
      end else begin
        mismatch <= (count != n_latched);
      end
    end
  end

endmodule

// File: tb/tb_stream_eot_sink.sv
// tb_stream_eot_sink: table-driven and randomized self-checking bench for
// stream_eot_sink. Results are predicted from the payload list alone.
module tb_stream_eot_sink;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 64;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [DATA_W:0]   in_s_dout;
  logic              in_s_empty_n;
  logic              in_s_read;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] checksum;
  logic              mismatch;

  int checks   = 0;
  int failures = 0;

  stream_eot_sink #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .in_s_dout    (in_s_dout),
    .in_s_empty_n (in_s_empty_n),
    .in_s_read    (in_s_read),
    .n            (n),
    .count        (count),
    .checksum     (checksum),
    .mismatch     (mismatch)
  );

  // Free-running clock
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [63:0]      n;
    logic [3:0]       len;
    logic [7:0][31:0] p;
    logic [3:0]       gap;
    logic [63:0]      exp_count;
    logic [31:0]      exp_sum;
    logic             exp_mm;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: a run's result depends only on the payload list and n
  function automatic void model(input int len, input logic [7:0][31:0] p,
                                input logic [63:0] n_val,
                                output logic [63:0] c, output logic [31:0] s,
                                output logic mm);
    longint unsigned sum = 0;
    for (int i = 0; i < len; i++) sum += p[i];
    c  = 64'(len);
    s  = sum[31:0];
    mm = (c != n_val);
  endfunction

  task automatic resetDut();
    ap_rst = 1'b1;
    ap_start = 1'b0;
    in_s_empty_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
  endtask

  // One run: optional start pulse, stream payloads then EoT, check DONE/IDLE.
  // consec: 0 = do not check read spacing, 1 = check per build.
  task automatic applyStimulus(input string tag, input logic [63:0] n_val,
                               input int len, input logic [7:0][31:0] p,
                               input int gap, input bit rnd_stall,
                               input bit poke_start, input bit skip_start,
                               input bit chain, input bit consec,
                               input logic [63:0] exp_count,
                               input logic [31:0] exp_sum, input logic exp_mm);
    int idx = 0, gaprem = 0, cyc = 0, reads = 0, first = -1, last = -1;
    int bad_read = 0, early_done = 0;
    if (!skip_start) begin
      n = n_val;
      ap_start = 1'b1;
      @(negedge ap_clk);
      checkOutput({tag, ".idle_before_start"}, ap_idle, 1);
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
    end
    while (idx <= len && cyc < 3000) begin
      ap_start = poke_start && (cyc % 4 == 1);
      if (rnd_stall) in_s_empty_n = ($urandom_range(0, 2) != 0);
      else if (gaprem > 0) begin
        in_s_empty_n = 1'b0;
        gaprem--;
      end else in_s_empty_n = 1'b1;
      if (!in_s_empty_n) in_s_dout = {1'b0, 32'($urandom)};
      else if (idx == len) in_s_dout = {1'b1, 32'($urandom)};
      else in_s_dout = {1'b0, p[idx]};
      @(negedge ap_clk);
      if (in_s_read === 1'b1 && !in_s_empty_n) bad_read++;
`ifndef STREAM_EOT_SINK_THROTTLE_EN
      if (in_s_read !== in_s_empty_n) bad_read++;
`endif
      if (ap_done !== 1'b0) early_done++;
      if (in_s_read === 1'b1) begin
        reads++;
        if (first < 0) first = cyc;
        last = cyc;
        idx++;
        gaprem = gap;
      end
      @(posedge ap_clk);
      #1 cyc++;
    end
    ap_start = 1'b0;
    if (idx <= len) begin
      checkOutput({tag, ".timeout"}, 1, 0);
      resetDut();
      return;
    end
    // DONE cycle: stream offers a word that must not be taken
    in_s_empty_n = 1'b1;
    in_s_dout = {1'b0, 32'h5};
    @(negedge ap_clk);
    checkOutput({tag, ".done"}, ap_done, 1);
    checkOutput({tag, ".ready"}, ap_ready, 1);
    checkOutput({tag, ".read_in_done"}, in_s_read, 0);
    checkOutput({tag, ".count"}, count, exp_count);
    checkOutput({tag, ".checksum"}, checksum, exp_sum);
    checkOutput({tag, ".mismatch"}, mismatch, exp_mm);
    checkOutput({tag, ".bad_read"}, bad_read, 0);
    checkOutput({tag, ".early_done"}, early_done, 0);
    checkOutput({tag, ".reads"}, reads, len + 1);
    if (consec) begin
`ifdef STREAM_EOT_SINK_THROTTLE_EN
      checkOutput({tag, ".consecutive"}, (last - first + 1) == reads, 0);
`else
      checkOutput({tag, ".consecutive"}, (last - first + 1) == reads, 1);
`endif
    end
    if (chain) ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    checkOutput({tag, ".done_one_cycle"}, ap_done, 0);
    checkOutput({tag, ".idle_after"}, ap_idle, 1);
    checkOutput({tag, ".no_read_idle"}, in_s_read, 0);
    checkOutput({tag, ".count_hold"}, count, exp_count);
    checkOutput({tag, ".mismatch_hold"}, mismatch, exp_mm);
    @(posedge ap_clk);
    #1;
    if (chain) begin
      ap_start = 1'b0;
      checkOutput({tag, ".chained_start"}, ap_idle, 0);
    end
    in_s_empty_n = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0][31:0] pl;
    logic [63:0] ec, nv;
    logic [31:0] es;
    logic em;
    int len;

    vecs[0] = '0; vecs[0].n = 5; vecs[0].len = 5;
    vecs[0].p[0] = 1; vecs[0].p[1] = 2; vecs[0].p[2] = 3; vecs[0].p[3] = 4; vecs[0].p[4] = 5;
    vecs[0].exp_count = 5; vecs[0].exp_sum = 15; vecs[0].exp_mm = 0;
    vecs[1] = vecs[0]; vecs[1].gap = 3;
    vecs[2] = '0; vecs[2].n = 3; vecs[2].len = 2;
    vecs[2].p[0] = 10; vecs[2].p[1] = 20;
    vecs[2].exp_count = 2; vecs[2].exp_sum = 30; vecs[2].exp_mm = 1;
    vecs[3] = '0; vecs[3].n = 2; vecs[3].len = 2;
    vecs[3].p[0] = 32'hFFFFFFFF; vecs[3].p[1] = 32'h00000002;
    vecs[3].exp_count = 2; vecs[3].exp_sum = 32'h00000001; vecs[3].exp_mm = 0;
    vecs[4] = '0; vecs[4].n = 7; vecs[4].len = 0;
    vecs[4].exp_count = 0; vecs[4].exp_sum = 0; vecs[4].exp_mm = 1;

    n = '0;
    in_s_dout = '0;
    ap_rst = 1'b1;
    ap_start = 1'b0;
    in_s_empty_n = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("reset.read_forced_low", in_s_read, 0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    checkOutput("reset.idle", ap_idle, 1);
    checkOutput("reset.done", ap_done, 0);
    checkOutput("reset.ready", ap_ready, 0);
    checkOutput("reset.read_idle", in_s_read, 0);
    checkOutput("reset.count", count, 0);
    checkOutput("reset.checksum", checksum, 0);
    checkOutput("reset.mismatch", mismatch, 0);
    @(posedge ap_clk);
    #1 in_s_empty_n = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].n, int'(vecs[i].len), vecs[i].p,
                    int'(vecs[i].gap), 1'b0, 1'b0, 1'b0, 1'b0, (i == 0),
                    vecs[i].exp_count, vecs[i].exp_sum, vecs[i].exp_mm);
    end

    // EoT-only run, then ap_start held through DONE starts the next run at once
    pl = '0;
    applyStimulus("eot_only", 64'd0, 0, pl, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  64'd0, 32'd0, 1'b0);
    pl[0] = 32'd7;
    applyStimulus("chained", 64'd0, 1, pl, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  64'd1, 32'd7, 1'b1);

    // Reset in the middle of a run
    n = 64'd5;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      in_s_empty_n = 1'b1;
      in_s_dout = {1'b0, 32'(k)};
      @(posedge ap_clk);
      #1;
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
`ifndef STREAM_EOT_SINK_THROTTLE_EN
    checkOutput("midreset.count_before", count, 2);
`endif
    checkOutput("midreset.read_during_reset", in_s_read, 0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    checkOutput("midreset.idle", ap_idle, 1);
    checkOutput("midreset.count", count, 0);
    checkOutput("midreset.checksum", checksum, 0);
    checkOutput("midreset.read", in_s_read, 0);
    @(posedge ap_clk);
    #1 in_s_empty_n = 1'b0;

    // Randomized runs against the reference model
    for (int r = 0; r < 16; r++) begin
      len = $urandom_range(0, 8);
      pl = '0;
      for (int j = 0; j < len; j++) pl[j] = $urandom;
      nv = ($urandom_range(0, 1) != 0) ? 64'(len) : 64'($urandom_range(0, 9));
      model(len, pl, nv, ec, es, em);
      applyStimulus($sformatf("rnd%0d", r), nv, len, pl, 0, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b0, ec, es, em);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
